// File: rtl/lk_flow_solver.sv
// lk_flow_solver: per-pixel Lucas-Kanade 2x2 solve using Cramer's rule.
// Tensor sums arrive as a valid-only stream into a small FIFO. One
// sequential solver pops an entry, forms det/num_u/num_v at full width, runs
// two restoring dividers in parallel and presents (u, v) on a valid/ready
// output port.
// Optional feature macro: FLOW_SOLVER_STATS_EN (saturating result counters).
module lk_flow_solver #(
  parameter int ACCUM_WIDTH = 32,
  parameter int FLOW_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DET_THRESH  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [ACCUM_WIDTH-1:0] sum_IxIx,
  input  logic signed [ACCUM_WIDTH-1:0] sum_IyIy,
  input  logic signed [ACCUM_WIDTH-1:0] sum_IxIy,
  input  logic signed [ACCUM_WIDTH-1:0] sum_IxIt,
  input  logic signed [ACCUM_WIDTH-1:0] sum_IyIt,
  input  logic [9:0]                    accum_x_coord,
  input  logic [8:0]                    accum_y_coord,
  input  logic                          accum_valid,
  output logic signed [FLOW_WIDTH-1:0]  flow_u,
  output logic signed [FLOW_WIDTH-1:0]  flow_v,
  output logic [9:0]                    flow_x_coord,
  output logic [8:0]                    flow_y_coord,
  output logic                          flow_degenerate,
  output logic                          flow_valid,
  input  logic                          flow_ready,
  output logic                          fifo_overflow,
  output logic [15:0]                   stat_solved,
  output logic [15:0]                   stat_degenerate
);

  // Products and their differences need 2*AW+2 bits so nothing truncates.
  localparam int PW = 2 * ACCUM_WIDTH + 2;
  // Divider working width: |num| << FRAC_BITS plus headroom for det << (FW-1).
  localparam int WW = PW + FRAC_BITS + FLOW_WIDTH;
  localparam int QW = FLOW_WIDTH - 1;
  localparam int CW = $clog2(FLOW_WIDTH);
  localparam int EW = 5 * ACCUM_WIDTH + 19;
  localparam int AB = $clog2(FIFO_DEPTH);

  localparam logic signed [PW-1:0] THRESH_S = PW'(DET_THRESH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  function automatic logic signed [PW-1:0] sext(input logic signed [ACCUM_WIDTH-1:0] val);
    sext = {{(PW-ACCUM_WIDTH){val[ACCUM_WIDTH-1]}}, val};
  endfunction

  // ---------------- input FIFO ----------------
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [AB-1:0] wr_ptr_r;
  logic [AB-1:0] rd_ptr_r;
  logic [AB:0]   cnt_r;
  logic [1:0]    state_r;

  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  assign entry_s = {sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt,
                    accum_x_coord, accum_y_coord};
  assign head_s  = mem_r[rd_ptr_r];
  assign full_s  = (cnt_r == (AB+1)'(FIFO_DEPTH));
  assign pop_s   = (state_r == ST_IDLE) && (cnt_r != '0);
  // A full FIFO still takes a beat when the solver drains one the same cycle.
  assign push_s  = accum_valid && (!full_s || pop_s);
  assign drop_s  = accum_valid && full_s && !pop_s;

  // FIFO storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      cnt_r         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AB'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AB'(1);
      end
      cnt_r <= cnt_r + (AB+1)'(push_s) - (AB+1)'(pop_s);
      if (drop_s) begin
        fifo_overflow <= 1'b1;
      end
    end
  end

  // ---------------- solver datapath ----------------
  logic signed [ACCUM_WIDTH-1:0] a_r, b_r, c_r, d_r, e_r;
  logic [9:0]                    x_r;
  logic [8:0]                    y_r;
  logic [WW-1:0]                 rem_u_r, rem_v_r, dsh_r;
  logic [QW-1:0]                 q_u_r, q_v_r;
  logic                          sat_u_r, sat_v_r, sgn_u_r, sgn_v_r, degen_r;
  logic [CW-1:0]                 div_cnt_r;

  logic signed [PW-1:0] det_s, num_u_s, num_v_s;
  logic [PW-1:0]        abs_u_s, abs_v_s;
  logic [WW-1:0]        dsh2_s;
  logic                 ge_u_s, ge_v_s;
  logic [FLOW_WIDTH-1:0] mag_u_s, mag_v_s, res_u_s, res_v_s;

  // a=IxIx b=IyIy c=IxIy d=IxIt e=IyIt
  assign det_s   = sext(a_r) * sext(b_r) - sext(c_r) * sext(c_r);
  assign num_u_s = sext(c_r) * sext(e_r) - sext(b_r) * sext(d_r);
  assign num_v_s = sext(c_r) * sext(d_r) - sext(a_r) * sext(e_r);
  assign abs_u_s = num_u_s[PW-1] ? -num_u_s : num_u_s;
  assign abs_v_s = num_v_s[PW-1] ? -num_v_s : num_v_s;

  // dsh_r walks det << (QW-1) down to det; doubled it is the saturation bound.
  assign dsh2_s  = {dsh_r[WW-2:0], 1'b0};
  assign ge_u_s  = (rem_u_r >= dsh_r);
  assign ge_v_s  = (rem_v_r >= dsh_r);

  assign mag_u_s = sat_u_r ? {1'b0, {QW{1'b1}}} : {1'b0, q_u_r};
  assign mag_v_s = sat_v_r ? {1'b0, {QW{1'b1}}} : {1'b0, q_v_r};
  // Negating a zero magnitude yields zero, so no result is ever -0.
  assign res_u_s = sgn_u_r ? -mag_u_s : mag_u_s;
  assign res_v_s = sgn_v_r ? -mag_v_s : mag_v_s;

  // Solver FSM: pop, full-width Cramer terms, bitwise division, output hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      {a_r, b_r, c_r, d_r, e_r, x_r, y_r} <= '0;
      rem_u_r         <= '0;
      rem_v_r         <= '0;
      dsh_r           <= '0;
      q_u_r           <= '0;
      q_v_r           <= '0;
      sat_u_r         <= 1'b0;
      sat_v_r         <= 1'b0;
      sgn_u_r         <= 1'b0;
      sgn_v_r         <= 1'b0;
      degen_r         <= 1'b0;
      div_cnt_r       <= '0;
      flow_u          <= '0;
      flow_v          <= '0;
      flow_x_coord    <= '0;
      flow_y_coord    <= '0;
      flow_degenerate <= 1'b0;
      flow_valid      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {a_r, b_r, c_r, d_r, e_r, x_r, y_r} <= head_s;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          q_u_r     <= '0;
          q_v_r     <= '0;
          sat_u_r   <= 1'b0;
          sat_v_r   <= 1'b0;
          div_cnt_r <= '0;
          if (det_s <= THRESH_S) begin
            sgn_u_r <= 1'b0;
            sgn_v_r <= 1'b0;
            degen_r <= 1'b1;
            state_r <= ST_OUT;
          end else begin
            rem_u_r <= {{FLOW_WIDTH{1'b0}}, abs_u_s, {FRAC_BITS{1'b0}}};
            rem_v_r <= {{FLOW_WIDTH{1'b0}}, abs_v_s, {FRAC_BITS{1'b0}}};
            dsh_r   <= {{(FRAC_BITS+2){1'b0}}, det_s, {(QW-1){1'b0}}};
            sgn_u_r <= num_u_s[PW-1];
            sgn_v_r <= num_v_s[PW-1];
            degen_r <= 1'b0;
            state_r <= ST_DIV;
          end
        end
        ST_DIV: begin
          // Quotient >= 2^QW would not fit; flag it once, before any subtraction.
          if (div_cnt_r == '0) begin
            sat_u_r <= (rem_u_r >= dsh2_s);
            sat_v_r <= (rem_v_r >= dsh2_s);
          end
          if (ge_u_s) begin
            rem_u_r <= rem_u_r - dsh_r;
          end
          if (ge_v_s) begin
            rem_v_r <= rem_v_r - dsh_r;
          end
          q_u_r     <= {q_u_r[QW-2:0], ge_u_s};
          q_v_r     <= {q_v_r[QW-2:0], ge_v_s};
          dsh_r     <= dsh_r >> 1;
          div_cnt_r <= div_cnt_r + CW'(1);
          if (div_cnt_r == CW'(QW - 1)) begin
            state_r <= ST_OUT;
          end
        end
        ST_OUT: begin
          // First OUT cycle applies sign/saturation; the result then holds.
          if (!flow_valid) begin
            flow_u          <= res_u_s;
            flow_v          <= res_v_s;
            flow_x_coord    <= x_r;
            flow_y_coord    <= y_r;
            flow_degenerate <= degen_r;
            flow_valid      <= 1'b1;
          end else if (flow_ready) begin
            flow_valid <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          flow_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLOW_SOLVER_STATS_EN
  // Saturating result counters, bumped on each accepted output.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_solved     <= 16'd0;
      stat_degenerate <= 16'd0;
    end else if (flow_valid && flow_ready) begin
      if (flow_degenerate) begin
        if (stat_degenerate != 16'hFFFF) begin
          stat_degenerate <= stat_degenerate + 16'd1;
        end
      end else begin
        if (stat_solved != 16'hFFFF) begin
          stat_solved <= stat_solved + 16'd1;
        end
      end
    end
  end
`else
  assign stat_solved     = 16'd0;
  assign stat_degenerate = 16'd0;
`endif

endmodule
